// File: rtl/dec_out_fmt.sv
// Decimating output formatter: keep one sample in dec_ratio+1, round/shift/saturate to OW bits, buffer in a FWFT FIFO.
// Optional macro DEC_OUT_FMT_SATCNT_EN adds a saturating sat_count output of clipped samples.
module dec_out_fmt #(
    parameter int unsigned IW    = 24,
    parameter int unsigned OW    = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IW-1:0]            in_data,
    input  logic                     in_valid,
    input  logic [3:0]               dec_ratio,
    input  logic [3:0]               shift,
    output logic [OW-1:0]            out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
`ifdef DEC_OUT_FMT_SATCNT_EN
    output logic [15:0]              sat_count,
`endif
    input  logic                     clear_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic signed [IW:0] SAT_HI = (IW+1)'((1 << (OW - 1)) - 1);
    localparam logic signed [IW:0] SAT_LO = ~SAT_HI;

    logic [3:0]              dcnt;
    logic                    keep;
    logic [3:0]              sh;
    logic signed [IW:0]      rnd;
    logic signed [IW:0]      sum;
    logic                    s1_valid;
    logic signed [IW:0]      s1_data;
    logic                    sat_hi;
    logic                    sat_lo;
    logic [OW-1:0]           sat_val;
    logic [OW-1:0]           mem [DEPTH];
    logic [AW:0]             wr_ptr;
    logic [AW:0]             rd_ptr;
    logic                    full;
    logic                    pop;
    logic                    push;
    logic                    drop;

    // Decimation select and rounding add, sized one bit wider than the input
    always_comb begin
        keep = in_valid && (dcnt >= dec_ratio);
        sh   = (shift > 4'd8) ? 4'd8 : shift;
        rnd  = (sh == 4'd0) ? '0 : ((IW+1)'(1) << (sh - 4'd1));
        sum  = $signed({in_data[IW-1], in_data}) + rnd;
    end

    // Saturation of the stage-1 result; the clipped value goes straight into the FIFO
    always_comb begin
        sat_hi  = s1_data > SAT_HI;
        sat_lo  = s1_data < SAT_LO;
        sat_val = s1_data[OW-1:0];
        if (sat_hi) begin
            sat_val = SAT_HI[OW-1:0];
        end else if (sat_lo) begin
            sat_val = SAT_LO[OW-1:0];
        end
    end

    always_comb begin
        full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop  = out_valid && out_ready;
        push = s1_valid && (!full || pop);
        drop = s1_valid && full && !pop;
    end

    assign fifo_level = wr_ptr - rd_ptr;
    assign out_valid  = (fifo_level != '0);
    assign out_data   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt     <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            if (in_valid) begin
                dcnt <= keep ? '0 : dcnt + 4'd1;
            end
            s1_valid <= keep;
            if (keep) begin
                s1_data <= sum >>> sh;
            end
        end
    end

    // FIFO storage and pointers; a full push with a same-cycle pop reuses the head slot
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= sat_val;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef DEC_OUT_FMT_SATCNT_EN
    logic clip;
    assign clip = s1_valid && (sat_hi || sat_lo);

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_count <= '0;
        end else if (clear_ovf) begin
            sat_count <= clip ? 16'd1 : 16'd0;
        end else if (clip && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/dec_out_fmt.md
Name: dec_out_fmt

Overview:
- Output formatting stage directly downstream of the moving-average/FIR filter.
- Consumes 24-bit signed filtered samples, decimates keep-one-in-N, then rounds, shifts and saturates each kept sample to 16 bits.
- Buffers formatted samples in a small first-word-fall-through FIFO drained by a valid/ready consumer (host/Wishbone-side reader).

Parameters:
- IW, 24, input sample width (signed)
- OW, 16, output sample width (signed)
- DEPTH, 4, FIFO depth in words; power of two, >= 2

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- in_data  input  IW  signed filtered sample from filter stage
- in_valid  input  1  in_data valid this cycle (filter enable/strobe)
- dec_ratio  input  4  keep one sample every dec_ratio+1 valid inputs
- shift  input  4  arithmetic right shift applied before saturation, 0..8
- out_data  output  OW  FIFO head sample, signed
- out_valid  output  1  FIFO not empty
- out_ready  input  1  consumer pops head when out_valid & out_ready
- fifo_level  output  $clog2(DEPTH)+1  words currently held
- overflow  output  1  sticky: a formatted sample was dropped
- clear_ovf  input  1  synchronous clear of overflow (and sat_count if present)

Behaviour:
- Reset values: out_data 0, out_valid 0, fifo_level 0, overflow 0; decimation counter 0; pipeline valid bits 0; FIFO pointers 0.
- Decimation counter dcnt (4 bits):
  - Advances only on in_valid.
  - On in_valid with dcnt >= dec_ratio: sample is kept and dcnt <= 0.
  - Otherwise dcnt <= dcnt+1 and the sample is discarded.
  - The >= compare makes a mid-stream decrease of dec_ratio take effect without wrapping. dec_ratio=0 keeps every sample.
- Stage 1, registered one cycle after the kept input:
  - r = (in_data + (shift==0 ? 0 : 1<<(shift-1))) >>> shift.
  - Computed at IW+1 bits so the rounding add cannot overflow. Round half up.
  - shift values > 8 are treated as 8.
- Stage 2, registered one cycle after stage 1:
  - Saturate r to [-2^(OW-1), 2^(OW-1)-1], i.e. -32768..32767.
  - Result is written to the FIFO on the same edge that stage 2 is valid.
- Latency: kept in_valid at edge N -> out_valid high after edge N+2 when the FIFO was empty.
- Throughput: one kept sample per cycle sustained.
- FIFO (first-word fall-through):
  - out_data = mem[rd_ptr].
  - out_valid = (fifo_level != 0).
  - Pop when out_valid & out_ready.
- Push to FIFO:
  - Accepted if not full, or if full and a pop occurs in the same cycle.
  - A push while full with no pop is dropped; overflow <= 1; FIFO contents unchanged.
- Simultaneous push and pop: fifo_level unchanged; both pointers advance.
- Pop when empty: impossible, since out_valid=0; out_ready is ignored.
- Pointer wrap: pointers carry one extra bit, so full = MSBs differ and remaining bits equal.
- overflow: set on a dropped push, cleared only by reset or clear_ovf. If clear_ovf and a drop occur in the same cycle, set wins.
- Reset mid-operation flushes the pipeline and FIFO; in-flight samples are lost. Out of reset, the first in_valid with dec_ratio=0 is kept.
- out_data is held stable while out_valid & !out_ready.

Optional Feature:
- Macro: DEC_OUT_FMT_SATCNT_EN.
- Defined:
  - Adds output port sat_count [15:0], reset 0.
  - Increments by 1 for each sample clipped in stage 2 (positive or negative); holds at 16'hFFFF.
  - clear_ovf clears it. A clip in the same cycle as clear_ovf yields 1.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Passthrough: dec_ratio=0, shift=0, out_ready=1, in_data=100 then -200 on consecutive cycles -> out_data 100 then -200 (16'hFF38); out_valid rises 2 cycles after first in_valid.
- Decimate: dec_ratio=3, in_data=0,1,2,...,11 every cycle -> FIFO receives 3, 7, 11 only.
- Round/saturate: shift=4, in_data=24'h000018 (24) -> 2; in_data=-24 -> -1; shift=0, in_data=24'h010000 -> 32767; in_data=24'hFF0000 -> -32768; with SATCNT_EN, sat_count=2 afterwards.
- Backpressure/overflow: DEPTH=4, out_ready=0, six kept samples 1..6 -> fifo_level=4, overflow=1. Then out_ready=1 -> reads 1,2,3,4. clear_ovf pulse -> overflow=0.
- Full with simultaneous pop: FIFO full with 10,11,12,13; a push of 14 coincident with a pop -> level stays 4, subsequent reads 11,12,13,14, overflow stays 0.
- Reset mid-stream: reset while FIFO holds 2 words and stage 1 is valid -> next cycle out_valid=0, fifo_level=0, overflow=0. The first in_valid after reset (dec_ratio=0) appears 2 cycles later.
